// File: rtl/counter_sequencer.sv
// Sequencer driving an external down-counter: configurable period and prescale,
// one-shot or auto-reload, with a one-cycle tick on each terminal count.
module counter_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [PS_W-1:0]  cfg_prescale,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  period_r;
    logic [PS_W-1:0]   prescale_r;
    logic              periodic_r;
    logic [PS_W-1:0]   ps_cnt;
    logic [PS_W-1:0]   ps_cnt_nxt;

    logic              idle_like;
    logic              cfg_hs;
    logic [WIDTH-1:0]  eff_period;
    logic              step;
    logic              term;
    logic              load_c;
    logic              en_c;
    logic              tick_c;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign cfg_hs     = cfg_valid && idle_like && !rst;
    // A start in the same cycle as a handshake sees the offered period.
    assign eff_period = cfg_hs ? cfg_period : period_r;
    assign step       = (state == RUN) && (ps_cnt == prescale_r);
    assign term       = step && (cnt_q == WIDTH'(1));

    // Next-state and counter-strobe logic
    always_comb begin
        state_nxt  = state;
        ps_cnt_nxt = ps_cnt;
        load_c     = 1'b0;
        en_c       = 1'b0;
        tick_c     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !stop && (eff_period != '0)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    load_c     = 1'b1;
                    ps_cnt_nxt = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    ps_cnt_nxt = step ? '0 : ps_cnt + PS_W'(1);
                    if (term) begin
                        tick_c = 1'b1;
                        if (periodic_r) begin
                            load_c = 1'b1;
                        end else begin
                            en_c      = 1'b1;
                            state_nxt = DONE;
                        end
                    end else if (step) begin
                        en_c = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, shadow configuration and prescale counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period_r   <= '0;
            prescale_r <= '0;
            periodic_r <= 1'b0;
            ps_cnt     <= '0;
        end else begin
            state  <= state_nxt;
            ps_cnt <= ps_cnt_nxt;
            if (cfg_hs) begin
                period_r   <= cfg_period;
                prescale_r <= cfg_prescale;
                periodic_r <= cfg_periodic;
            end
        end
    end

    // Reset masks the outputs so they are defined before the first edge.
    assign cfg_ready    = rst || idle_like;
    assign cnt_load     = !rst && load_c;
    assign cnt_en       = !rst && en_c;
    assign tick         = !rst && tick_c;
    assign cnt_load_val = rst ? '0 : period_r;
    assign busy         = !rst && ((state == LOAD) || (state == RUN));
    assign done         = !rst && (state == DONE);

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the width of the counter value and the period.
REQ-002 The block SHALL have parameter PS_W, default 4, setting the width of the prescaler setting.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  in  1  clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port cfg_valid  in  1  configuration offer.
REQ-007 Port cfg_ready  out  1  configuration can be accepted.
REQ-008 Port cfg_period  in  WIDTH  terminal-count period P.
REQ-009 Port cfg_prescale  in  PS_W  prescale S; the counter steps once every S+1 cycles.
REQ-010 Port cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
REQ-011 Port start  in  1  start request.
REQ-012 Port stop  in  1  abort request.
REQ-013 Port cnt_load  out  1  load strobe to the controlled counter.
REQ-014 Port cnt_load_val  out  WIDTH  load value, always equal to the registered period.
REQ-015 Port cnt_en  out  1  decrement strobe to the controlled counter.
REQ-016 Port cnt_q  in  WIDTH  current value of the controlled counter.
REQ-017 Port busy  out  1  high in LOAD or RUN.
REQ-018 Port tick  out  1  one-cycle terminal-count pulse.
REQ-019 Port done  out  1  level, high in DONE.

Function
REQ-020 The controlled counter SHALL obey this contract: if cnt_load, q <= cnt_load_val; else if cnt_en, q <= q-1 modulo 2^WIDTH; cnt_load and cnt_en are never both high.
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and DONE; cnt_load, cnt_en and tick are combinational from state, registers and cnt_q.
REQ-022 cfg_ready SHALL be 1 in IDLE and DONE and 0 in LOAD and RUN.
REQ-023 A configuration handshake (cfg_valid & cfg_ready) SHALL capture period, prescale and periodic into shadow registers.
REQ-024 If cfg_valid is high while cfg_ready is low, the offer SHALL be ignored and no configuration register SHALL change.
REQ-025 In IDLE or DONE, start=1 & stop=0 with registered period (after any same-cycle capture) non-zero SHALL move the FSM to LOAD.
REQ-026 A start that coincides with a configuration handshake SHALL use the newly captured values.
REQ-027 A start with period 0 SHALL be ignored, leaving state and done unchanged.
REQ-028 LOAD SHALL last exactly one cycle: cnt_load=1, prescale counter cleared to 0, next state RUN.
REQ-029 In RUN, the prescale counter SHALL increment each cycle.
REQ-030 In RUN, the cycle where the prescale count equals S is a step cycle: cnt_en=1 and the prescale counter returns to 0.
REQ-031 A step cycle with cnt_q==1 is the terminal step: tick=1.
REQ-032 On a periodic terminal step, cnt_load=1 replaces cnt_en and the FSM stays in RUN; tick spacing SHALL be exactly P*(S+1) cycles.
REQ-033 On a one-shot terminal step, cnt_en=1, the counter reaches 0 and the next state is DONE.
REQ-034 The first tick SHALL occur P*(S+1)+1 cycles after the cycle in which start was sampled.
REQ-035 stop in LOAD or RUN SHALL return the FSM to IDLE next cycle and force cnt_load=cnt_en=tick=0 in that cycle; stop has priority over a terminal step.
REQ-036 start in LOAD or RUN SHALL be ignored; stop in IDLE or DONE SHALL be ignored; start&stop together in IDLE or DONE SHALL be ignored.
REQ-037 DONE SHALL behave as IDLE, except done=1; start leaves DONE via LOAD and clears done.
REQ-038 A cnt_q value of 0 at a step cycle (external disturbance) SHALL not produce a tick; the counter wraps.

Reset
REQ-039 rst=1 SHALL, at the next edge, force IDLE and clear period, prescale, periodic and the prescale counter to 0; rst has priority over all inputs.
REQ-040 While in reset and after reset, the outputs SHALL be cfg_ready=1, cnt_load_val=0 and busy=done=tick=cnt_load=cnt_en=0.
REQ-041 Reset mid-RUN SHALL produce no tick and no cnt_load or cnt_en in the cycle following the reset edge.

Verification
REQ-042 The bench SHALL pair the block with a behavioural counter implementing REQ-020 and cover these directed scenarios:
- P=3, S=0, one-shot, start at cycle 0 -> cnt_load at cycle 1, tick only at cycle 4, done=1 from cycle 5, cnt_q=0.
- P=2, S=1, periodic, start at cycle 0 -> ticks at cycles 5, 9, 13; cnt_load at cycles 1, 5, 9; busy held at 1.
- Periodic run, stop asserted in a terminal-step cycle -> no tick, no load, IDLE next cycle, busy=0.
- cfg_valid during RUN -> cfg_ready=0 and registers unchanged; in DONE, cfg P=5 together with start -> cnt_load_val=5 at LOAD.
- cfg period 0 then start -> stays IDLE with busy=0; rst during RUN -> IDLE with all outputs per REQ-040.
